// File: rtl/spi_mstr_mss_if.sv
// ---------------------------------------------------------------------------
// spi_mstr_mss_if
// Bundles the command-side handshake and the SPI pin signals of the
// multi-slave SPI master.
//   master modport : the SPI master itself (takes wrt/ss_sel/cmd/MISO,
//                    drives SCLK/MOSI/SS_n/busy/done/data/err)
//   slave modport  : the sequencer / pin side facing the master
// Widths follow DATA_W / NUM_SS / SS_W and must match the master instance.
// ---------------------------------------------------------------------------
interface spi_mstr_mss_if #(
    parameter int DATA_W = 16,
    parameter int NUM_SS = 5,
    parameter int SS_W   = 3
) ();
    logic              wrt;
    logic [SS_W-1:0]   ss_sel;
    logic [DATA_W-1:0] cmd;
    logic              MISO;
    logic              SCLK;
    logic              MOSI;
    logic [NUM_SS-1:0] SS_n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data;
    logic              err;

    modport master (
        input  wrt, ss_sel, cmd, MISO,
        output SCLK, MOSI, SS_n, busy, done, data, err
    );

    modport slave (
        output wrt, ss_sel, cmd, MISO,
        input  SCLK, MOSI, SS_n, busy, done, data, err
    );
endinterface

// File: rtl/spi_mstr_mss.sv
// ---------------------------------------------------------------------------
// spi_mstr_mss
// Multi-slave SPI master with integrated one-cold slave-select decode.
// A transaction is SETUP (half SCLK period, SCLK idle, first bit on MOSI),
// SHIFT (DATA_W full SCLK periods, MSB first), HOLD (half period, select
// still low) and GAP (GAP_CYC cycles with every select high).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : spi_mstr_mss_if.master (wrt, ss_sel, cmd, MISO in;
//          SCLK, MOSI, SS_n, busy, done, data, err out)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module spi_mstr_mss #(
    parameter int DATA_W   = 16,
    parameter int NUM_SS   = 5,
    parameter int SS_W     = 3,
    parameter int SCLK_DIV = 32,
    parameter int CPOL     = 1,
    parameter int GAP_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_mstr_mss_if.master    bus
);

    localparam int   HALF   = SCLK_DIV / 2;
    localparam int   DIV_W  = $clog2(SCLK_DIV);
    localparam int   BIT_W  = $clog2(DATA_W + 1);
    localparam int   GAP_W  = $clog2(GAP_CYC + 1);
    localparam logic CPOL_L = (CPOL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [BIT_W-1:0]    r_bit;
    logic [GAP_W-1:0]    r_gap;
    logic [DATA_W-1:0]   r_shift;
    logic                r_sample;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_SS-1:0]   r_ss_n;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;

    logic                w_sel_ok;
    logic                w_accept;
    logic                w_illegal;
    logic                w_half_end;
    logic                w_per_end;
    logic                w_last_bit;
    logic                w_capture;
    logic                w_shift;
    logic                w_hold_exit;
    logic                w_sclk_nxt;
    logic [NUM_SS-1:0]   w_ss_dec;

    // Extra MSB on the compare so NUM_SS == 2**SS_W is representable.
    assign w_sel_ok    = ({1'b0, bus.ss_sel} < (SS_W + 1)'(NUM_SS));
    assign w_accept    = (r_state == S_IDLE) && bus.wrt && w_sel_ok;
    assign w_illegal   = (r_state == S_IDLE) && bus.wrt && !w_sel_ok;
    assign w_half_end  = (r_div == DIV_W'(HALF - 1));
    assign w_per_end   = (r_div == DIV_W'(SCLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
    // MISO is captured on the edge that takes SCLK away from idle,
    // and the shift happens on the edge that returns SCLK to idle.
    assign w_capture   = (r_state == S_SHIFT) && w_half_end;
    assign w_shift     = (r_state == S_SHIFT) && w_per_end;
    assign w_hold_exit = (r_state == S_HOLD) && w_half_end;

    // One-cold decode of the requested slave select.
    always_comb begin
        w_ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            w_ss_dec[i] = (bus.ss_sel != SS_W'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and divider-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (w_half_end) begin
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_SHIFT: begin
                if (w_per_end) begin
                    w_div_nxt = '0;
                    if (w_last_bit) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (w_half_end) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // SCLK leaves idle only in the second half of each SHIFT bit period;
    // it is derived from the next state so the flop lines up with it.
    always_comb begin
        if ((w_state_nxt == S_SHIFT) && (w_div_nxt >= DIV_W'(HALF))) begin
            w_sclk_nxt = ~CPOL_L;
        end else begin
            w_sclk_nxt = CPOL_L;
        end
    end

    // Datapath: counters, shift register, selects and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div    <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
            r_shift  <= '0;
            r_sample <= 1'b0;
            r_sclk   <= CPOL_L;
            r_mosi   <= 1'b0;
            r_ss_n   <= '1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_sclk <= w_sclk_nxt;
            r_err  <= w_illegal;
            r_busy <= (w_state_nxt != S_IDLE);
            if (r_state == S_GAP) begin
                r_gap <= r_gap + GAP_W'(1);
            end else begin
                r_gap <= '0;
            end
            if (w_accept) begin
                r_shift <= bus.cmd;
                r_mosi  <= bus.cmd[DATA_W-1];
                r_ss_n  <= w_ss_dec;
                r_bit   <= '0;
                r_done  <= 1'b0;
            end else if (w_capture) begin
                r_sample <= bus.MISO;
            end else if (w_shift) begin
                r_shift <= {r_shift[DATA_W-2:0], r_sample};
                r_mosi  <= r_shift[DATA_W-2];
                r_bit   <= r_bit + BIT_W'(1);
            end else if (w_hold_exit) begin
                r_ss_n <= '1;
                r_data <= r_shift;
                r_done <= 1'b1;
                r_mosi <= 1'b0;
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    assign bus.SCLK = r_sclk;
    assign bus.MOSI = r_mosi;
    assign bus.SS_n = r_ss_n;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.data = r_data;
    assign bus.err  = r_err;

endmodule
